// File: rtl/lenet5_pkg.sv
// Shared types and arithmetic helpers for the LeNet-5 datapath blocks.
package lenet5_pkg;

  typedef enum logic {
    ACT_LINEAR = 1'b0,
    ACT_RELU   = 1'b1
  } act_mode_e;

  // Accumulator wide enough for K*K full-precision products plus a bias term.
  function automatic int acc_width(input int data_w, input int coef_w, input int k);
    return data_w + coef_w + $clog2(k * k) + 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle: data, valid, ready and end-of-frame marker.
interface axis_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport controller (output tdata, output tvalid, output tlast, input tready);
  modport peripheral (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/conv_line_buffer.sv
// Raster-order line buffer: K-1 stored rows feed a KxK sliding window that
// shifts one column per accepted pixel; window_valid marks complete windows.
module conv_line_buffer #(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_W      = 8
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               stall,
  input  logic                                               in_valid,
  input  logic                                               in_last,
  input  logic [DATA_W-1:0]                                  in_data,
  output logic                                               at_last,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_W-1:0]     window,
  output logic                                               window_valid,
  output logic                                               window_last
);
  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              win_vld_q, win_vld_d;
  logic              win_last_q, win_last_d;
  logic [DATA_W-1:0] lb_q  [K-1][IMG_W];
  logic [DATA_W-1:0] lb_d  [K-1][IMG_W];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];

  assign at_last = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    lb_d       = lb_q;
    win_d      = win_q;
    win_vld_d  = stall ? win_vld_q : 1'b0;
    win_last_d = stall ? win_last_q : 1'b0;
    if (in_valid) begin
      // Window shifts left; the new right column is the stored rows above plus the new pixel.
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_d[i][j] = win_q[i][j+1];
      end
      for (int i = 0; i < K - 1; i++) win_d[i][K-1] = lb_q[i][col_q];
      win_d[K-1][K-1] = in_data;
      for (int i = 0; i < K - 2; i++) lb_d[i][col_q] = lb_q[i+1][col_q];
      lb_d[K-2][col_q] = in_data;
      win_vld_d  = (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1));
      win_last_d = at_last;
      if (at_last || in_last) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      win_vld_q  <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_vld_q  <= win_vld_d;
      win_last_q <= win_last_d;
    end
  end

  always_ff @(posedge clk) begin
    lb_q  <= lb_d;
    win_q <= win_d;
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) window[i*K+j] = win_q[i][j];
    end
  end

  assign window_valid = win_vld_q;
  assign window_last  = win_last_q;

endmodule

// File: rtl/conv_layer.sv
// Streaming valid-mode KxK convolution with NUM_FILTERS parallel filters:
// products, adder tree + bias, then shift/saturate/activate into the output beat.
module conv_layer
  import lenet5_pkg::*;
#(
  parameter int        IMG_W       = 32,
  parameter int        IMG_H       = 32,
  parameter int        KERNEL_SIZE = 5,
  parameter int        NUM_FILTERS = 6,
  parameter int        DATA_W      = 8,
  parameter int        COEF_W      = 8,
  parameter int        FRAC_SHIFT  = 0,
  parameter act_mode_e ACT_MODE    = ACT_LINEAR,
  localparam int       ACC_W       = acc_width(DATA_W, COEF_W, KERNEL_SIZE),
  localparam int       ADDR_W      = $clog2(NUM_FILTERS * (KERNEL_SIZE * KERNEL_SIZE + 1))
) (
  input  logic              clk,
  input  logic              rst_n,
  axis_if.peripheral        s_axis,
  axis_if.controller        m_axis,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [ACC_W-1:0]  coef_wdata,
  output logic              busy,
  output logic              frame_err
);
  localparam int K      = KERNEL_SIZE;
  localparam int KK     = K * K;
  localparam int F      = NUM_FILTERS;
  localparam int PROD_W = DATA_W + COEF_W;

  logic                      stall, accept, frame_end, pipe_empty, out_last_hs;
  logic                      lb_at_last, win_vld, win_last;
  logic [KK-1:0][DATA_W-1:0] win;

  logic signed [COEF_W-1:0]  tap_q  [F][KK];
  logic signed [COEF_W-1:0]  tap_d  [F][KK];
  logic signed [ACC_W-1:0]   bias_q [F];
  logic signed [ACC_W-1:0]   bias_d [F];

  logic signed [PROD_W-1:0]  prod_p1_q [F][KK];
  logic signed [PROD_W-1:0]  prod_p1_d [F][KK];
  logic signed [ACC_W-1:0]   acc_p2_q  [F];
  logic signed [ACC_W-1:0]   acc_p2_d  [F];
  logic                      vld_p1_q, last_p1_q, vld_p2_q, last_p2_q;
  logic                      m_tvalid_q, m_tlast_q;
  logic [F*DATA_W-1:0]       m_tdata_q, m_tdata_d;

  logic                      in_frame_q, in_frame_d;
  logic                      pend_q, pend_d;
  logic                      pend_err_q, pend_err_d;
  logic                      frame_err_q, frame_err_d;

  function automatic logic [DATA_W-1:0] activate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      clamped;
    shifted = acc >>> FRAC_SHIFT;
    clamped = saturate(64'(shifted), DATA_W);
    if (ACT_MODE == ACT_RELU && clamped < 0) clamped = '0;
    return clamped[DATA_W-1:0];
  endfunction

  assign stall          = m_tvalid_q && !m_axis.tready;
  assign s_axis.tready  = !stall;
  assign accept         = s_axis.tvalid && !stall;
  assign frame_end      = lb_at_last || s_axis.tlast;
  assign out_last_hs    = m_tvalid_q && m_axis.tready && m_tlast_q;
  assign pipe_empty     = !win_vld && !vld_p1_q && !vld_p2_q && !m_tvalid_q;
  assign m_axis.tvalid  = m_tvalid_q;
  assign m_axis.tdata   = m_tdata_q;
  assign m_axis.tlast   = m_tlast_q;
  assign busy           = in_frame_q || pend_q;
  assign frame_err      = frame_err_q;

  conv_line_buffer #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .KERNEL_SIZE (K),
    .DATA_W      (DATA_W)
  ) u_line_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .in_valid     (accept),
    .in_last      (s_axis.tlast),
    .in_data      (s_axis.tdata),
    .at_last      (lb_at_last),
    .window       (win),
    .window_valid (win_vld),
    .window_last  (win_last)
  );

  // Coefficients only change between frames so in-flight windows see one set.
  always_comb begin
    tap_d  = tap_q;
    bias_d = bias_q;
    if (coef_we && !busy) begin
      for (int f = 0; f < F; f++) begin
        for (int k = 0; k < KK; k++) begin
          if (coef_addr == ADDR_W'(f * (KK + 1) + k)) tap_d[f][k] = coef_wdata[COEF_W-1:0];
        end
        if (coef_addr == ADDR_W'(f * (KK + 1) + KK)) bias_d[f] = coef_wdata;
      end
    end
  end

  always_comb begin
    prod_p1_d = '{default: '0};
    acc_p2_d  = '{default: '0};
    m_tdata_d = '0;
    for (int f = 0; f < F; f++) begin
      for (int k = 0; k < KK; k++) begin
        prod_p1_d[f][k] = PROD_W'(tap_q[f][k]) * PROD_W'($signed(win[k]));
      end
      acc_p2_d[f] = bias_q[f];
      for (int k = 0; k < KK; k++) acc_p2_d[f] = acc_p2_d[f] + ACC_W'(prod_p1_q[f][k]);
      m_tdata_d[f*DATA_W +: DATA_W] = activate(acc_p2_q[f]);
    end
  end

  // An early tlast frame has no tlast beat, so it ends when the pipeline drains.
  always_comb begin
    in_frame_d  = in_frame_q;
    pend_d      = pend_q;
    pend_err_d  = pend_err_q;
    frame_err_d = frame_err_q;
    if (pend_q && (pend_err_q ? pipe_empty : out_last_hs)) pend_d = 1'b0;
    if (accept) begin
      in_frame_d = !frame_end;
      if (frame_end) begin
        pend_d     = 1'b1;
        pend_err_d = !lb_at_last;
      end
      if (s_axis.tlast && !lb_at_last) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < F; f++) begin
        bias_q[f] <= '0;
        for (int k = 0; k < KK; k++) tap_q[f][k] <= '0;
      end
      in_frame_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      bias_q      <= bias_d;
      in_frame_q  <= in_frame_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  // S1 products | S2 adder tree + bias | S3 shift/sat/activation into m_axis
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      vld_p2_q   <= 1'b0;
      last_p2_q  <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
    end else if (!stall) begin
      vld_p1_q   <= win_vld;
      last_p1_q  <= win_last;
      vld_p2_q   <= vld_p1_q;
      last_p2_q  <= last_p1_q;
      m_tvalid_q <= vld_p2_q;
      m_tlast_q  <= last_p2_q;
      m_tdata_q  <= m_tdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      prod_p1_q <= prod_p1_d;
      acc_p2_q  <= acc_p2_d;
    end
  end

endmodule

// File: tb/tb_conv_layer.sv
// Directed bench for conv_layer: 6x6 image, K=3, two filters, three instances
// (ReLU, linear, linear with shift 1) driven in lockstep from one stream.
module tb_conv_layer;
  import lenet5_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, m_tready;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [20:0] coef_wdata;
  logic        busy_a, busy_b, busy_c, ferr_a, ferr_b, ferr_c;
  bit          bp_en;
  int          n_assert, n_fail;
  int          img  [36];
  int          tap  [2][9];
  int          bias [2];
  logic [16:0] qa [$];
  logic [16:0] qb [$];
  logic [16:0] qc [$];

  always #5 clk = ~clk;

  axis_if #(.W(8))  sa ();
  axis_if #(.W(8))  sb ();
  axis_if #(.W(8))  sc ();
  axis_if #(.W(16)) ma ();
  axis_if #(.W(16)) mb ();
  axis_if #(.W(16)) mc ();

  assign sa.tdata = s_tdata;  assign sa.tvalid = s_tvalid;  assign sa.tlast = s_tlast;
  assign sb.tdata = s_tdata;  assign sb.tvalid = s_tvalid;  assign sb.tlast = s_tlast;
  assign sc.tdata = s_tdata;  assign sc.tvalid = s_tvalid;  assign sc.tlast = s_tlast;
  assign ma.tready = m_tready;
  assign mb.tready = m_tready;
  assign mc.tready = m_tready;

  conv_layer #(.IMG_W(6), .IMG_H(6), .KERNEL_SIZE(3), .NUM_FILTERS(2), .DATA_W(8), .COEF_W(8),
               .FRAC_SHIFT(0), .ACT_MODE(ACT_RELU)) ua (
    .clk(clk), .rst_n(rst_n), .s_axis(sa), .m_axis(ma), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy_a), .frame_err(ferr_a));

  conv_layer #(.IMG_W(6), .IMG_H(6), .KERNEL_SIZE(3), .NUM_FILTERS(2), .DATA_W(8), .COEF_W(8),
               .FRAC_SHIFT(0), .ACT_MODE(ACT_LINEAR)) ub (
    .clk(clk), .rst_n(rst_n), .s_axis(sb), .m_axis(mb), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy_b), .frame_err(ferr_b));

  conv_layer #(.IMG_W(6), .IMG_H(6), .KERNEL_SIZE(3), .NUM_FILTERS(2), .DATA_W(8), .COEF_W(8),
               .FRAC_SHIFT(1), .ACT_MODE(ACT_LINEAR)) uc (
    .clk(clk), .rst_n(rst_n), .s_axis(sc), .m_axis(mc), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy_c), .frame_err(ferr_c));

  always @(negedge clk) begin
    if (ma.tvalid && m_tready) qa.push_back({ma.tlast, ma.tdata});
    if (mb.tvalid && m_tready) qb.push_back({mb.tlast, mb.tdata});
    if (mc.tvalid && m_tready) qc.push_back({mc.tlast, mc.tdata});
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_acc(input int f, input int r, input int c);
    int s = bias[f];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += tap[f][i*3+j] * img[(r+i)*6 + c + j];
    return s;
  endfunction

  function automatic int post(input int acc, input int shift, input bit relu);
    int v;
    v = acc >>> shift;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  function automatic int fval(input logic [16:0] b, input int f);
    logic [7:0] v;
    v = b[f*8 +: 8];
    return int'($signed(v));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
  endtask

  task automatic send(input int pix, input bit last);
    bit done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = pix[7:0];
    s_tlast  = last;
    for (int t = 0; t < 200 && !done; t++) begin
      done = sa.tready;
      step();
    end
    if (!done) chk("s_tready_timeout", 0, 1);
  endtask

  task automatic wcoef(input int addr, input int val);
    coef_we    = 1'b1;
    coef_addr  = addr[4:0];
    coef_wdata = val[20:0];
    step();
    coef_we    = 1'b0;
  endtask

  task automatic load_coefs();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 9; k++) wcoef(f*10 + k, tap[f][k]);
      wcoef(f*10 + 9, bias[f]);
    end
  endtask

  task automatic set_taps(input int t0, input int t1);
    for (int k = 0; k < 9; k++) begin
      tap[0][k] = t0;
      tap[1][k] = t1;
    end
  endtask

  task automatic run_frame(input int npix, input int tlast_at, input bit bp, input bit poke);
    qa.delete(); qb.delete(); qc.delete();
    bp_en = bp;
    for (int p = 0; p < npix; p++) begin
      if (poke && p == 10) begin
        coef_we = 1'b1; coef_addr = 5'd4; coef_wdata = 21'd99;
      end
      send(img[p], p == tlast_at);
      coef_we = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    for (int t = 0; t < 500 && (busy_a || busy_b || busy_c); t++) step();
    bp_en = 1'b0;
    repeat (4) step();
    chk("busy_idle_after_frame", int'(busy_a | busy_b | busy_c), 0);
  endtask

  task automatic check_frame(input int n, input bit last_exp, input string tn);
    for (int u = 0; u < 3; u++) begin
      int sz = (u == 0) ? qa.size() : (u == 1) ? qb.size() : qc.size();
      chk($sformatf("%s_u%0d_count", tn, u), sz, n);
      for (int i = 0; i < n && i < sz; i++) begin
        logic [16:0] b = (u == 0) ? qa[i] : (u == 1) ? qb[i] : qc[i];
        for (int f = 0; f < 2; f++)
          chk($sformatf("%s_u%0d_b%0d_f%0d", tn, u, i, f), fval(b, f),
              post(ref_acc(f, i / 4, i % 4), (u == 2) ? 1 : 0, u == 0));
        chk($sformatf("%s_u%0d_b%0d_tlast", tn, u, i), int'(b[16]),
            (last_exp && i == n - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; bp_en = 1'b0;
    rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    chk("rst_tvalid", int'(ma.tvalid | mb.tvalid | mc.tvalid), 0);
    chk("rst_tdata", int'(ma.tdata | mb.tdata | mc.tdata), 0);
    chk("rst_tlast", int'(ma.tlast | mb.tlast | mc.tlast), 0);
    chk("rst_busy", int'(busy_a | busy_b | busy_c), 0);
    chk("rst_frame_err", int'(ferr_a | ferr_b | ferr_c), 0);
    chk("rst_s_tready", int'(sa.tready), 1);

    // All-ones image, f0 taps +1, f1 taps -1, zero bias.
    for (int p = 0; p < 36; p++) img[p] = 1;
    set_taps(1, -1); bias[0] = 0; bias[1] = 0;
    load_coefs();
    run_frame(36, 35, 0, 0);
    check_frame(16, 1, "ones");
    chk("ones_relu_f0", fval(qa[0], 0), 9);
    chk("ones_relu_f1", fval(qa[0], 1), 0);

    // f1 bias 4: linear -5, shifted floor(4.5)=4 and floor(-2.5)=-3.
    bias[1] = 4;
    wcoef(19, 4);
    run_frame(36, 35, 0, 0);
    check_frame(16, 1, "bias");
    chk("bias_lin_f1", fval(qb[15], 1), -5);
    chk("bias_shift_f0", fval(qc[15], 0), 4);
    chk("bias_shift_f1", fval(qc[15], 1), -3);

    // Saturation at both rails.
    for (int p = 0; p < 36; p++) img[p] = 127;
    set_taps(127, -128); bias[0] = 0; bias[1] = 0;
    load_coefs();
    run_frame(36, 35, 0, 0);
    check_frame(16, 1, "sat");
    chk("sat_hi", fval(qb[7], 0), 127);
    chk("sat_lo", fval(qb[7], 1), -128);

    // Ramp image with random backpressure; f0 = centre pixel, f1 = 2*TL - BR.
    for (int p = 0; p < 36; p++) img[p] = p;
    set_taps(0, 0); tap[0][4] = 1; tap[1][0] = 2; tap[1][8] = -1;
    load_coefs();
    run_frame(36, 35, 1, 0);
    check_frame(16, 1, "ramp_bp");
    chk("ramp_first_f0", fval(qb[0], 0), 7);
    chk("ramp_last_f1", fval(qb[15], 1), 7);

    // Early tlast on pixel 20: five windows drain without tlast.
    run_frame(21, 20, 0, 0);
    check_frame(5, 0, "early");
    chk("early_frame_err_a", int'(ferr_a), 1);
    chk("early_frame_err_c", int'(ferr_c), 1);
    run_frame(36, 35, 0, 0);
    check_frame(16, 1, "after_early");
    chk("frame_err_sticky", int'(ferr_b), 1);

    // Reset in the middle of a frame.
    s_tlast = 1'b0;
    for (int p = 0; p < 17; p++) send(img[p], 1'b0);
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_tvalid", int'(ma.tvalid | mb.tvalid | mc.tvalid), 0);
    chk("midrst_busy", int'(busy_a | busy_b | busy_c), 0);
    chk("midrst_frame_err", int'(ferr_a | ferr_b | ferr_c), 0);
    rst_n = 1'b1;
    step();
    load_coefs();
    run_frame(36, 35, 0, 0);
    check_frame(16, 1, "after_rst");

    // Coefficient write while busy is ignored.
    run_frame(36, 35, 0, 1);
    check_frame(16, 1, "busy_write");
    chk("busy_write_f0_b5", fval(qb[5], 0), 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer.md
# conv_layer

Parametrised streaming 2D convolution layer for the LeNet-5 pipeline. It accepts a raster-order single-channel image on an AXI-stream and computes NUM_FILTERS valid-mode KxK convolutions (stride 1) in parallel. Each result gets bias, fixed-point rescale, saturation and a selectable activation, and results go out as one packed beat per window position. It replaces the per-filter convolution instances in the lenet5 top and is reused for conv layers 1–3 by changing parameters.

## Interface
- IMG_W, 32: input image width in pixels (≥ KERNEL_SIZE)
- IMG_H, 32: input image height in pixels (≥ KERNEL_SIZE)
- KERNEL_SIZE, 5: square kernel edge K
- NUM_FILTERS, 6: parallel output channels F
- DATA_W, 8: signed pixel/result width
- COEF_W, 8: signed coefficient width
- FRAC_SHIFT, 0: arithmetic right shift applied to accumulator
- ACT_MODE, 0: 0 = linear (saturate only), 1 = ReLU
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low
- s_axis  axis_if.peripheral  DATA_W  pixels; tlast on last pixel of frame
- m_axis  axis_if.controller  F*DATA_W  filter f at bits [f*DATA_W +: DATA_W]; tlast on last window
- coef_we  input  1  coefficient write strobe
- coef_addr  input  $clog2(F*(K*K+1))  address f*(K*K+1)+k, k in 0..K*K-1 is the tap (row-major), k = K*K is the bias
- coef_wdata  input  ACC_W  tap uses low COEF_W bits (sign-extended), bias uses full ACC_W
- busy  output  1  frame in progress
- frame_err  output  1  sticky: tlast arrived at a pixel other than IMG_W*IMG_H-1

## Operation
- ACC_W = DATA_W+COEF_W+$clog2(K*K)+1; products and sums are signed, full precision, no overflow.
- Line buffer: K-1 rows of IMG_W pixels plus a KxK window shift register, fed on every accepted pixel.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on s_axis handshake; col wraps to 0 and increments row; both clear after the last pixel.
- Window valid when col ≥ K-1 and row ≥ K-1. This gives (IMG_W-K+1)*(IMG_H-K+1) outputs per frame, in raster order.
- Result per filter: acc = bias + Σ tap*pixel, then acc >>> FRAC_SHIFT (floor), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then ReLU if ACT_MODE=1.
- m_axis tlast is set on the window completed by pixel (IMG_W-1, IMG_H-1).
- busy rises on the first accepted pixel of a frame and falls after the tlast output beat handshakes.
- Early s_axis tlast:
  - set frame_err;
  - clear col/row and the line buffer valid state;
  - outputs already in the pipeline drain normally, with no m_axis tlast emitted;
  - busy falls once the pipeline is empty.
- A missing tlast on the last pixel does not cause an error; counters wrap anyway.
- Coefficient writes are accepted only while busy=0 and ignored otherwise. Coefficients are flops, reset to 0.

## Timing
- Pipeline stages: S1 register products, S2 register adder tree + bias, S3 register shift/sat/activation into the m_axis output register.
- Latency is 3 cycles from the handshake of the window-completing pixel to m_axis tvalid, with no backpressure.
- Global stall when m_axis tvalid && !tready: all stages hold and s_axis tready=0. Otherwise s_axis tready=1 (combinational from the output handshake).
- Throughput is one pixel per cycle.
- Reset values: tvalid=0, tdata=0, tlast=0, busy=0, frame_err=0, counters=0, stage valids=0, coefficients=0.
- Reset mid-frame discards everything; the next frame starts at pixel (0,0).
- frame_err is cleared only by reset.

## Structure
- Package lenet5_pkg: ACC_W function, act_mode_e enum (ACT_LINEAR, ACT_RELU), saturation function.
- Sub-module conv_line_buffer (K-1 row FIFOs + KxK window, outputs window array + window_valid, stall input).
- MAC, adder tree and activation stay in conv_layer.

## Test plan
- IMG 6x6, K=3, F=2, all pixels 1, f0 taps all 1 bias 0, f1 taps all -1 bias 0, ACT_MODE=1 -> 16 beats, f0=9, f1=0, tlast only on beat 16.
- Same config, ACT_MODE=0, f1 bias=4 -> f1 = -5 on all 16 beats; FRAC_SHIFT=1 -> f0=4, f1=-3 (floor).
- DATA_W=8, pixels 127, taps 127 -> f0 saturates to 127; taps -128 -> -128.
- Random m_axis tready (50%) on a 6x6 ramp image -> output sequence identical to no-backpressure golden model, no beats lost or duplicated.
- tlast on pixel 20 of 36 -> frame_err=1, no output tlast; the next full frame produces the correct 16 beats.
- Reset low at pixel 17, then a full frame -> exactly 16 correct beats.
- coef_we during busy -> coefficients unchanged, results match the pre-write values.
